// File: rtl/cpu8080_pkg.sv
// rtl/cpu8080_pkg.sv - 8080 opcode constants and instruction length encodings
package cpu8080_pkg;

  typedef enum logic [1:0] {
    LEN_1 = 2'd1,
    LEN_2 = 2'd2,
    LEN_3 = 2'd3
  } ilen_t;

  // Register-pair / condition-code families are matched as mask + pattern
  localparam logic [7:0] RP_MASK  = 8'hCF;
  localparam logic [7:0] LXI_PAT  = 8'h01;
  localparam logic [7:0] DDD_MASK = 8'hC7;
  localparam logic [7:0] MVI_PAT  = 8'h06;
  localparam logic [7:0] JCC_PAT  = 8'hC2;
  localparam logic [7:0] CCC_PAT  = 8'hC4;

  localparam logic [7:0] OP_SHLD = 8'h22;
  localparam logic [7:0] OP_LHLD = 8'h2A;
  localparam logic [7:0] OP_STA  = 8'h32;
  localparam logic [7:0] OP_LDA  = 8'h3A;
  localparam logic [7:0] OP_JMP  = 8'hC3;
  localparam logic [7:0] OP_CALL = 8'hCD;

  localparam logic [7:0] OP_ADI = 8'hC6;
  localparam logic [7:0] OP_ACI = 8'hCE;
  localparam logic [7:0] OP_SUI = 8'hD6;
  localparam logic [7:0] OP_SBI = 8'hDE;
  localparam logic [7:0] OP_ANI = 8'hE6;
  localparam logic [7:0] OP_XRI = 8'hEE;
  localparam logic [7:0] OP_ORI = 8'hF6;
  localparam logic [7:0] OP_CPI = 8'hFE;
  localparam logic [7:0] OP_IN  = 8'hDB;
  localparam logic [7:0] OP_OUT = 8'hD3;

endpackage

// File: rtl/inst_len.sv
// rtl/inst_len.sv - combinational 8080 opcode length decode
module inst_len
  import cpu8080_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] len
);

  ilen_t l;

  always_comb begin
    l = LEN_1;
    if (((opcode & RP_MASK) == LXI_PAT) ||
        ((opcode & DDD_MASK) == JCC_PAT) ||
        ((opcode & DDD_MASK) == CCC_PAT) ||
        (opcode inside {OP_SHLD, OP_LHLD, OP_STA, OP_LDA, OP_JMP, OP_CALL})) begin
      l = LEN_3;
    end else if (((opcode & DDD_MASK) == MVI_PAT) ||
                 (opcode inside {OP_ADI, OP_ACI, OP_SUI, OP_SBI, OP_ANI,
                                 OP_XRI, OP_ORI, OP_CPI, OP_IN, OP_OUT})) begin
      l = LEN_2;
    end
  end

  assign len = l;

endmodule

// File: rtl/fetch_align.sv
// rtl/fetch_align.sv - 16-bit fetch into byte queue, aligned 8080 instruction output
module fetch_align
  import cpu8080_pkg::*;
#(
  parameter int QDEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_ren,
  output logic [15:0] mem_raddr,
  input  logic [15:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_instr,
  output logic [1:0]  out_len,
  output logic [15:0] out_pc
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    q [QDEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [15:0]   fetch_addr;
  logic          inflight, drop, odd_start;
  logic [1:0]    head_len;
  logic [1:0]    push_n;
  logic          push, pop;
  logic [CW:0]   room_need;

  inst_len u_inst_len (
    .opcode (q[head]),
    .len    (head_len)
  );

  // Reserve room for the response already on its way before issuing another
  always_comb begin
    room_need = {1'b0, count} + (inflight ? (CW+1)'(4) : (CW+1)'(2));
    mem_ren   = rst_n && !redirect_valid && (room_need <= (CW+1)'(QDEPTH));
    mem_raddr = fetch_addr;
    out_valid = rst_n && !redirect_valid && (count >= CW'(head_len));
    out_len   = head_len;
    out_instr = {q[head],
                 (head_len >= 2'd2) ? q[head + PW'(1)] : 8'h00,
                 (head_len == 2'd3) ? q[head + PW'(2)] : 8'h00};
    push      = inflight && !drop;
    push_n    = odd_start ? 2'd1 : 2'd2;
    pop       = out_valid && out_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      fetch_addr <= 16'h0000;
      out_pc     <= 16'h0000;
      inflight   <= 1'b0;
      drop       <= 1'b0;
      odd_start  <= 1'b0;
    end else if (redirect_valid) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      fetch_addr <= {redirect_pc[15:1], 1'b0};
      out_pc     <= redirect_pc;
      odd_start  <= redirect_pc[0];
      drop       <= inflight;
      inflight   <= 1'b0;
    end else begin
      inflight <= mem_ren;
      drop     <= 1'b0;
      if (mem_ren)
        fetch_addr <= fetch_addr + 16'd2;
      if (push) begin
        tail      <= tail + PW'(push_n);
        odd_start <= 1'b0;
      end
      if (pop) begin
        head   <= head + PW'(head_len);
        out_pc <= out_pc + 16'(head_len);
      end
      count <= count + (push ? CW'(push_n) : '0) - (pop ? CW'(head_len) : '0);
    end
  end

  // An odd redirect target keeps only the upper byte of the first response
  always_ff @(posedge clk) begin
    if (rst_n && !redirect_valid && push) begin
      if (odd_start) begin
        q[tail] <= mem_rdata[15:8];
      end else begin
        q[tail]          <= mem_rdata[7:0];
        q[tail + PW'(1)] <= mem_rdata[15:8];
      end
    end
  end

endmodule

// File: tb/tb_fetch_align.sv
// tb/tb_fetch_align.sv - directed self-checking bench for fetch_align
module tb_fetch_align;

  logic        clk;
  logic        rst_n;
  logic        mem_ren;
  logic [15:0] mem_raddr;
  logic [15:0] mem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_instr;
  logic [1:0]  out_len;
  logic [15:0] out_pc;

  logic [7:0] mem [65536];
  int n_checks;
  int n_fail;

  fetch_align #(.QDEPTH(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_ren        (mem_ren),
    .mem_raddr      (mem_raddr),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_len        (out_len),
    .out_pc         (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-cycle-latency memory
  always @(posedge clk) begin
    if (mem_ren)
      mem_rdata <= {mem[mem_raddr + 16'd1], mem[mem_raddr]};
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic get_instr(input string tag, input logic [23:0] ei,
                           input logic [1:0] el, input logic [15:0] ep);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!out_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    if (out_valid) begin
      check_eq({tag, "_instr"}, 32'(out_instr), 32'(ei));
      check_eq({tag, "_len"}, 32'(out_len), 32'(el));
      check_eq({tag, "_pc"}, 32'(out_pc), 32'(ep));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int waited;
    n_checks = 0;
    n_fail = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[0] = 8'h00; mem[1] = 8'h3E; mem[2] = 8'h42;
    mem[3] = 8'hC3; mem[4] = 8'h34; mem[5] = 8'h12;
    for (int i = 0; i < 16; i++) mem[6 + i] = 8'h40 + 8'(i);
    mem[16'hFFFE] = 8'h21; mem[16'hFFFF] = 8'hAB;
    mem[16'h0104] = 8'h77; mem[16'h0105] = 8'h06; mem[16'h0106] = 8'h99;
    mem[16'h0300] = 8'hC3; mem[16'h0301] = 8'h00; mem[16'h0302] = 8'h01;
    mem[16'h0400] = 8'hFF; mem[16'h0401] = 8'hFF;

    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    out_ready = 1'b0;

    // Reset and basic decode of 00 / MVI / JMP
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ren", 32'(mem_ren), 32'd0);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("first_ren", 32'(mem_ren), 32'd1);
    check_eq("first_addr", 32'(mem_raddr), 32'h0000);
    get_instr("nop0", 24'h000000, 2'd1, 16'h0000);
    get_instr("mvi", 24'h3E4200, 2'd2, 16'h0001);
    get_instr("jmp", 24'hC33412, 2'd3, 16'h0003);

    // Backpressure: queue fills, fetch stalls, output holds, nothing lost
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("full_ren", 32'(mem_ren), 32'd0);
    check_eq("full_valid", 32'(out_valid), 32'd1);
    check_eq("full_pc", 32'(out_pc), 32'h0006);
    check_eq("full_instr", 32'(out_instr), 32'h400000);
    for (int i = 0; i < 12; i++)
      get_instr("stream", {8'h40 + 8'(i), 16'h0000}, 2'd1, 16'h0006 + 16'(i));

    // LXI straddling the top of memory
    mem[0] = 8'h5A;
    redirect_pc = 16'hFFFE;
    redirect_valid = 1'b1;
    @(negedge clk);
    check_eq("redir_valid", 32'(out_valid), 32'd0);
    check_eq("redir_ren", 32'(mem_ren), 32'd0);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    check_eq("wrap_ren", 32'(mem_ren), 32'd1);
    check_eq("wrap_addr", 32'(mem_raddr), 32'hFFFE);
    get_instr("lxi_wrap", 24'h21AB5A, 2'd3, 16'hFFFE);
    get_instr("after_wrap", 24'h3E4200, 2'd2, 16'h0001);

    // Redirect to odd address while a response is arriving
    redirect_pc = 16'h0200;
    redirect_valid = 1'b1;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    check_eq("pre_ren", 32'(mem_ren), 32'd1);
    check_eq("pre_addr", 32'(mem_raddr), 32'h0200);
    @(posedge clk); #1;
    redirect_pc = 16'h0105;
    redirect_valid = 1'b1;
    @(negedge clk);
    check_eq("drop_valid", 32'(out_valid), 32'd0);
    check_eq("drop_ren", 32'(mem_ren), 32'd0);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    check_eq("odd_ren", 32'(mem_ren), 32'd1);
    check_eq("odd_addr", 32'(mem_raddr), 32'h0104);
    get_instr("odd_mvi", 24'h069900, 2'd2, 16'h0105);

    // Redirect wins over a same-cycle accept
    waited = 0;
    @(negedge clk);
    while (!out_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check_eq("pre_hs_valid", 32'(out_valid), 32'd1);
    check_eq("pre_hs_pc", 32'(out_pc), 32'h0107);
    @(posedge clk); #1;
    redirect_pc = 16'h0300;
    redirect_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("hs_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    get_instr("hs_jmp", 24'hC30001, 2'd3, 16'h0300);
    get_instr("hs_next", 24'h000000, 2'd1, 16'h0303);

    // Reset with a request outstanding
    redirect_pc = 16'h0400;
    redirect_valid = 1'b1;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_ren", 32'(mem_ren), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_ren", 32'(mem_ren), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("post_rst_valid", 32'(out_valid), 32'd0);
    check_eq("post_rst_ren", 32'(mem_ren), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    get_instr("rst_first", 24'h5A0000, 2'd1, 16'h0000);
    get_instr("rst_second", 24'h3E4200, 2'd2, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
